xmem_arbiter: RTL and testbench
===============================

XMEM_ARBITER -- requirements
Module: xmem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023; number of consecutive wait cycles before a stalled cycle is forcibly ended (range 2..1023).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_adr_i[2:31], m0_dat_i[0:31], m0_we_i, m0_sel_i[0:3], m0_stb_i, m0_cyc_i  input  Wishbone master 0 (service processor) request.
REQ-005 m0_dat_o[0:31], m0_ack_o  output  master 0 read data and acknowledge.
REQ-006 m1_adr_i[2:31], m1_dat_i[0:31], m1_we_i, m1_sel_i[0:3], m1_stb_i, m1_cyc_i  input  Wishbone master 1 (ROM/bank fetch engine) request.
REQ-007 m1_dat_o[0:31], m1_ack_o  output  master 1 read data and acknowledge.
REQ-008 s_adr_o[2:31], s_dat_o[0:31], s_we_o, s_sel_o[0:3], s_stb_o, s_cyc_o  output  shared slave port to the DDR2 memory wrapper.
REQ-009 s_dat_i[0:31], s_ack_i  input  slave read data and acknowledge.
REQ-010 grant_o[0:1]  output  2  one-hot current owner (bit 0 = m0, bit 1 = m1); 00 when idle.
REQ-011 timeout_o  output  1  sticky flag, set when a cycle was forcibly terminated.

Function
REQ-012 The arbiter SHALL implement states IDLE, OWN0, OWN1.
REQ-013 In IDLE, a request from exactly one master (cyc high) SHALL move to that master's OWN state at the next edge.
REQ-014 In IDLE with both cyc high, the grant SHALL go to the master not granted last (round-robin; last-owner register resets to m1, so m0 wins the first tie).
REQ-015 Arbitration latency SHALL be exactly one cycle: s_cyc_o asserts the cycle after the state enters OWNx, never in IDLE.
REQ-016 In OWNx, s_adr_o, s_dat_o, s_we_o, s_sel_o SHALL be combinationally muxed from master x; s_cyc_o = mx_cyc_i; s_stb_o = mx_stb_i & mx_cyc_i.
REQ-017 In OWNx, mx_ack_o SHALL equal s_ack_i & mx_stb_i & mx_cyc_i, mx_dat_o SHALL equal s_dat_i; the non-owner's ack SHALL be 0 and its dat_o all-zero.
REQ-018 Ownership SHALL persist across multiple stb/ack transfers while mx_cyc_i remains high (locked burst).
REQ-019 When the owner drops cyc, the state SHALL return to IDLE at the next edge; one idle cycle separates owners.
REQ-020 A non-owner's request SHALL remain pending without effect and be served from IDLE per REQ-013/014.
REQ-021 In IDLE all slave outputs SHALL be 0 and both acks 0.
REQ-022 grant_o SHALL be registered and reflect the current state.

Reset
REQ-023 Assertion of rst_n low SHALL immediately force state IDLE, last owner m1, grant_o = 00, timeout_o = 0, timeout counter 0, and all slave/master outputs 0, including mid-cycle.
REQ-024 After rst_n deasserts, the first arbitration SHALL occur on the first edge where a cyc is sampled high.

Configuration
REQ-025 With macro XMEM_ARBITER_TIMEOUT_EN defined, a counter SHALL increment each cycle s_stb_o is high and s_ack_i low, and clear on s_ack_i or in IDLE.
REQ-026 When that counter reaches TIMEOUT_CYCLES, the arbiter SHALL, for one cycle, assert the owner's ack with dat_o = 32'hFFFFFFFF, deassert s_cyc_o/s_stb_o, set timeout_o, and clear the counter.
REQ-027 timeout_o SHALL stay set until reset.
REQ-028 Without XMEM_ARBITER_TIMEOUT_EN, no counter SHALL exist, timeout_o SHALL be constant 0, and a stalled slave stalls the owner indefinitely.

Verification
REQ-029 m0 single read of adr 30'h0000100, slave acks after 3 cycles with 32'h12345678 -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o pulses once with m0_dat_o = 32'h12345678, m1_ack_o stays 0.
REQ-030 m0 and m1 raise cyc on the same edge after reset -> grant_o = 10 first; after m0 drops cyc, one IDLE cycle, then grant_o = 01.
REQ-031 m0 holds cyc for a 4-beat burst while m1 requests -> all 4 acks go to m0, m1 granted only after m0 cyc falls.
REQ-032 Both masters continuously re-request -> grants alternate 10, 01, 10, 01.
REQ-033 rst_n pulsed low mid-transfer (s_stb_o high) -> s_cyc_o, acks and grant_o drop to 0 in the same cycle, no ack delivered.
REQ-034 With XMEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never acks -> owner ack pulses after 8 wait cycles with dat 32'hFFFFFFFF, timeout_o = 1 and stays 1.

Source files
------------

// File: rtl/xmem_arbiter.sv
// xmem_arbiter: two-master Wishbone arbiter (service processor, ROM/bank fetch) sharing one DDR2 slave port.
// Optional stalled-cycle watchdog is compiled in when XMEM_ARBITER_TIMEOUT_EN is defined.
module xmem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:31] m0_adr_i,
   input  logic [0:31] m0_dat_i,
   input  logic        m0_we_i,
   input  logic [0:3]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [0:31] m0_dat_o,
   output logic        m0_ack_o,
   input  logic [2:31] m1_adr_i,
   input  logic [0:31] m1_dat_i,
   input  logic        m1_we_i,
   input  logic [0:3]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [0:31] m1_dat_o,
   output logic        m1_ack_o,
   output logic [2:31] s_adr_o,
   output logic [0:31] s_dat_o,
   output logic        s_we_o,
   output logic [0:3]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [0:31] s_dat_i,
   input  logic        s_ack_i,
   output logic [0:1]  grant_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

   localparam int unsigned CNT_W = 10;

   state_e     state_q, state_d;
   logic       last_q, last_d;     // 0 = m0 owned last, 1 = m1 owned last
   logic [0:1] grant_q, grant_d;
   logic       fire;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? OWN0 : OWN1;
               last_d  = ~last_q;
            end else if (m0_cyc_i) begin
               state_d = OWN0;
               last_d  = 1'b0;
            end else if (m1_cyc_i) begin
               state_d = OWN1;
               last_d  = 1'b1;
            end
         end
         OWN0:    if (!m0_cyc_i) state_d = IDLE;
         OWN1:    if (!m1_cyc_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      grant_d = {state_d == OWN0, state_d == OWN1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
      end
   end

   // Owner's request is steered straight through; a watchdog hit substitutes an error ack.
   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_stb_o  = 1'b0;
      s_cyc_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_dat_o = '0;
      case (state_q)
         OWN0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_cyc_o  = m0_cyc_i & ~fire;
            s_stb_o  = m0_stb_i & m0_cyc_i & ~fire;
            m0_ack_o = fire | (s_ack_i & m0_stb_i & m0_cyc_i);
            m0_dat_o = fire ? '1 : s_dat_i;
         end
         OWN1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_cyc_o  = m1_cyc_i & ~fire;
            s_stb_o  = m1_stb_i & m1_cyc_i & ~fire;
            m1_ack_o = fire | (s_ack_i & m1_stb_i & m1_cyc_i);
            m1_dat_o = fire ? '1 : s_dat_i;
         end
         default: ;
      endcase
   end

   assign grant_o = grant_q;

`ifdef XMEM_ARBITER_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q;

   assign fire = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) || s_ack_i || fire) begin
         cnt_d = '0;
      end else if (s_stb_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_q | fire;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_timeout_cfg;

   assign fire               = 1'b0;
   assign timeout_o          = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) && (CNT_W != 0);
`endif

endmodule

// File: tb/tb_xmem_arbiter.sv
// Scoreboard bench for xmem_arbiter: expected acks/grants are queued by the stimulus
// and popped by independent monitors whenever the DUT presents an ack or a new grant.
module tb_xmem_arbiter;

   logic        clk;
   logic        rst_n = 1'b1;
   logic [2:31] m0_adr_i, m1_adr_i, s_adr_o;
   logic [0:31] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic        m0_we_i, m1_we_i, s_we_o;
   logic [0:3]  m0_sel_i, m1_sel_i, s_sel_o;
   logic        m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i;
   logic        m0_ack_o, m1_ack_o, s_stb_o, s_cyc_o, s_ack_i;
   logic [0:1]  grant_o;
   logic        timeout_o;

   typedef struct {
      int          m;
      logic [31:0] dat;
   } exp_t;

   exp_t       exp_q[$];
   logic [0:1] gnt_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         slv_wait = 1;
   int         slv_cnt  = 0;

   xmem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] slave_rd(input logic [2:31] a);
      case (a[28:31])
         4'd0:    return 32'h12345678;
         4'd1:    return 32'hDEADBEEF;
         4'd2:    return 32'h0BADF00D;
         4'd3:    return 32'hCAFEBABE;
         4'd4:    return 32'h13579BDF;
         4'd5:    return 32'h2468ACE0;
         4'd6:    return 32'h0F0F0F0F;
         4'd7:    return 32'hA5A5A5A5;
         default: return 32'h0;
      endcase
   endfunction

   task automatic expect_ack(input int m, input logic [31:0] d);
      exp_t e;
      e.m   = m;
      e.dat = d;
      exp_q.push_back(e);
   endtask

   function automatic logic ack_of(input int m);
      return (m == 0) ? m0_ack_o : m1_ack_o;
   endfunction

   task automatic set_m(input int m, input logic cyc, input logic stb, input logic [2:31] adr,
                        input logic we, input logic [0:31] dat);
      if (m == 0) begin
         m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we; m0_dat_i = dat; m0_sel_i = 4'hF;
      end else begin
         m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_sel_i = 4'h3;
      end
   endtask

   // Locked burst of 'beats' transfers at consecutive addresses; cyc drops after the last ack.
   task automatic run_master(input int m, input logic [2:31] adr, input int beats,
                             input logic we, input logic [0:31] wdat);
      int          waited;
      logic [2:31] a;
      @(posedge clk); #1;
      for (int b = 0; b < beats; b++) begin
         a = adr + 30'(b);
         set_m(m, 1'b1, 1'b1, a, we, wdat);
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (!ack_of(m) && waited < 300);
         if (!ack_of(m)) begin
            check("ack_wait_expired", 32'(ack_of(m)), 32'd1);
         end else begin
            check("s_adr_mux", 32'(s_adr_o), 32'(a));
            check("s_we_mux", 32'(s_we_o), 32'(we));
            check("s_dat_mux", 32'(s_dat_o), 32'(wdat));
            check("s_sel_mux", 32'(s_sel_o), (m == 0) ? 32'hF : 32'h3);
         end
         @(posedge clk); #1;
      end
      set_m(m, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   // Slave: fixed read data per address, ack after slv_wait wait cycles, single-cycle ack.
   initial begin : slave_model
      s_ack_i = 1'b0;
      s_dat_i = '0;
      forever begin
         @(posedge clk); #2;
         if (!rst_n || s_ack_i) begin
            s_ack_i = 1'b0;
            s_dat_i = '0;
            slv_cnt = 0;
         end else if (s_cyc_o && s_stb_o) begin
            if (slv_cnt >= slv_wait) begin
               s_ack_i = 1'b1;
               s_dat_i = slave_rd(s_adr_o);
            end else begin
               slv_cnt++;
            end
         end else begin
            slv_cnt = 0;
         end
      end
   end

   initial begin : ack_monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (m0_ack_o || m1_ack_o) begin
            check("ack_onehot", 32'(m0_ack_o & m1_ack_o), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 32'({m0_ack_o, m1_ack_o}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ack_master", m1_ack_o ? 32'd1 : 32'd0, 32'(e.m));
               check("ack_data", m1_ack_o ? 32'(m1_dat_o) : 32'(m0_dat_o), e.dat);
               check("nonowner_dat", m1_ack_o ? 32'(m0_dat_o) : 32'(m1_dat_o), 32'd0);
            end
         end
      end
   end

   initial begin : grant_monitor
      logic [0:1] prev_g;
      prev_g = 2'b00;
      forever begin
         @(negedge clk);
         if (grant_o !== prev_g && grant_o !== 2'b00) begin
            check("grant_idle_gap", 32'(prev_g), 32'd0);
            if (gnt_q.size() == 0) check("unexpected_grant", 32'(grant_o), 32'd0);
            else                   check("grant_order", 32'(grant_o), 32'(gnt_q.pop_front()));
         end
         prev_g = grant_o;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      set_m(0, 1'b0, 1'b0, '0, 1'b0, '0);
      set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
      #1 rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
      check("rst_s_stb", 32'(s_stb_o), 32'd0);
      check("rst_s_adr", 32'(s_adr_o), 32'd0);
      check("rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
      check("rst_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Simultaneous request after reset: m0 wins, then m1 (write) after one idle cycle
      slv_wait = 1;
      gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
      expect_ack(0, 32'hDEADBEEF); expect_ack(1, 32'h0BADF00D);
      fork
         run_master(0, 30'h0000101, 1, 1'b0, 32'h0);
         run_master(1, 30'h0000202, 1, 1'b1, 32'h55AA55AA);
      join
      repeat (3) @(negedge clk);

      // Single m0 read with 3 wait states; s_cyc_o one cycle after m0_cyc_i
      slv_wait = 3;
      gnt_q.push_back(2'b10);
      expect_ack(0, 32'h12345678);
      fork
         run_master(0, 30'h0000100, 1, 1'b0, 32'h0);
         begin
            @(posedge clk);
            @(negedge clk);
            check("lat_idle_s_cyc", 32'(s_cyc_o), 32'd0);
            check("lat_idle_grant", 32'(grant_o), 32'd0);
            @(negedge clk);
            check("lat_own_s_cyc", 32'(s_cyc_o), 32'd1);
            check("lat_own_grant", 32'(grant_o), 32'h2);
         end
      join
      repeat (3) @(negedge clk);

      // m0 locked 4-beat burst while m1 waits
      slv_wait = 2;
      gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
      expect_ack(0, 32'h13579BDF); expect_ack(0, 32'h2468ACE0);
      expect_ack(0, 32'h0F0F0F0F); expect_ack(0, 32'hA5A5A5A5);
      expect_ack(1, 32'hCAFEBABE);
      fork
         run_master(0, 30'h0000104, 4, 1'b0, 32'h0);
         begin
            @(posedge clk);
            run_master(1, 30'h0000203, 1, 1'b0, 32'h0);
         end
      join
      repeat (3) @(negedge clk);

      // Continuous re-requests alternate owners
      slv_wait = 1;
      gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
      gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
      expect_ack(0, 32'hDEADBEEF); expect_ack(1, 32'h0BADF00D);
      expect_ack(0, 32'hCAFEBABE); expect_ack(1, 32'h12345678);
      fork
         begin
            run_master(0, 30'h0000101, 1, 1'b0, 32'h0);
            run_master(0, 30'h0000103, 1, 1'b0, 32'h0);
         end
         begin
            run_master(1, 30'h0000102, 1, 1'b0, 32'h0);
            run_master(1, 30'h0000100, 1, 1'b0, 32'h0);
         end
      join
      repeat (3) @(negedge clk);

`ifdef XMEM_ARBITER_TIMEOUT_EN
      // Slave never acks: forced error ack after 8 wait cycles, sticky timeout flag
      slv_wait = 100000;
      gnt_q.push_back(2'b10);
      expect_ack(0, 32'hFFFFFFFF);
      @(posedge clk); #1;
      set_m(0, 1'b1, 1'b1, 30'h0000106, 1'b0, '0);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m0_ack_o) break;
         if (s_stb_o) n++;
      end
      check("to_ack_seen", 32'(m0_ack_o), 32'd1);
      check("to_wait_cycles", 32'(n), 32'd8);
      check("to_s_cyc_low", 32'(s_cyc_o), 32'd0);
      check("to_s_stb_low", 32'(s_stb_o), 32'd0);
      @(posedge clk); #1;
      set_m(0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      check("to_flag_set", 32'(timeout_o), 32'd1);
      slv_wait = 1;
      gnt_q.push_back(2'b01);
      expect_ack(1, 32'h12345678);
      run_master(1, 30'h0000100, 1, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      check("to_flag_sticky", 32'(timeout_o), 32'd1);
      #1 rst_n = 1'b0;
      #1 check("to_flag_reset", 32'(timeout_o), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
`else
      // Slave never acks: owner stays stalled, no ack, no timeout flag
      slv_wait = 100000;
      gnt_q.push_back(2'b10);
      @(posedge clk); #1;
      set_m(0, 1'b1, 1'b1, 30'h0000106, 1'b0, '0);
      repeat (40) @(negedge clk);
      check("stall_s_cyc", 32'(s_cyc_o), 32'd1);
      check("stall_s_stb", 32'(s_stb_o), 32'd1);
      check("stall_grant", 32'(grant_o), 32'h2);
      check("stall_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk); #1;
      set_m(0, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (3) @(negedge clk);
`endif

      // Reset pulsed mid-transfer while s_stb_o is high
      slv_wait = 5;
      gnt_q.push_back(2'b01);
      @(posedge clk); #1;
      set_m(1, 1'b1, 1'b1, 30'h0000205, 1'b0, '0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_stb_o && n < 20);
      check("mid_stb_before", 32'(s_stb_o), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_s_cyc", 32'(s_cyc_o), 32'd0);
      check("mid_s_stb", 32'(s_stb_o), 32'd0);
      check("mid_grant", 32'(grant_o), 32'd0);
      check("mid_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
      check("mid_s_adr", 32'(s_adr_o), 32'd0);
      set_m(1, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);

      check("pending_acks", 32'(exp_q.size()), 32'd0);
      check("pending_grants", 32'(gnt_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
